// File: rtl/spacewar_pkg.sv
// Shared widths, table entry layout and scan FSM encoding for the spacewar
// line renderer.
package spacewar_pkg;

  localparam int COORD_W   = 5;
  localparam int MAX_LINES = 8;
  localparam int IDX_W     = $clog2(MAX_LINES);

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [IDX_W-1:0]   idx_t;

  typedef struct packed {
    coord_t x1;
    coord_t y1;
    coord_t x3;
    coord_t y3;
  } line_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

endpackage

// File: rtl/line_table.sv
// Line segment register file: per-entry valid bits, write/clear with a
// lockout while a frame is in progress, and one combinational read port.
module line_table
  import spacewar_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  busy_i,
  input  logic  wr_en_i,
  input  idx_t  wr_idx_i,
  input  line_t wr_line_i,
  input  logic  tbl_clr_i,
  input  idx_t  rd_idx_i,
  output line_t rd_line_o,
  output logic  rd_valid_o
);

  line_t                entry_q [MAX_LINES];
  logic [MAX_LINES-1:0] valid_q;
  logic                 wr_take;

  // Clear has priority over a simultaneous write.
  assign wr_take = wr_en_i && !tbl_clr_i && !busy_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (!busy_i) begin
      if (tbl_clr_i) begin
        valid_q <= '0;
      end else if (wr_en_i) begin
        valid_q[wr_idx_i] <= 1'b1;
      end
    end
  end

  // Endpoint data carries no reset; it is meaningless until its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_take) begin
      entry_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_line_o  = entry_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/line_scan_sequencer.sv
// Raster-scans the 32x32 grid, presents each table entry to the external
// on-line checker per pixel, and streams one lit/unlit result per pixel.
module line_scan_sequencer
  import spacewar_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COORD_W-1:0] wr_x1,
  input  logic [COORD_W-1:0] wr_y1,
  input  logic [COORD_W-1:0] wr_x3,
  input  logic [COORD_W-1:0] wr_y3,
  input  logic               tbl_clr,
  input  logic               start,
  output logic [COORD_W-1:0] chk_x1,
  output logic [COORD_W-1:0] chk_y1,
  output logic [COORD_W-1:0] chk_x2,
  output logic [COORD_W-1:0] chk_y2,
  output logic [COORD_W-1:0] chk_x3,
  output logic [COORD_W-1:0] chk_y3,
  input  logic               chk_on_segment,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_lit,
  output logic               busy,
  output logic               frame_done
);

  scan_state_t state_q, state_d;
  coord_t      x_q, x_d, y_q, y_d;
  idx_t        idx_q, idx_d;
  logic        acc_q, acc_d;
  line_t       chk_line_q, chk_line_d;
  logic        chk_valid_q, chk_valid_d;
  logic        pix_lit_q, pix_lit_d;

  idx_t        rd_idx;
  line_t       rd_line;
  logic        rd_valid;
  logic        busy_w;

  assign busy_w = (state_q == CHECK) || (state_q == EMIT);

  // Operands are registered, so the read port looks one entry ahead in CHECK
  // and at entry 0 whenever the next cycle may begin a new pixel.
  assign rd_idx = (state_q == CHECK) ? idx_t'(idx_q + 1'b1) : '0;

  line_table u_line_table (
    .clk        (clk),
    .reset      (reset),
    .busy_i     (busy_w),
    .wr_en_i    (wr_en),
    .wr_idx_i   (wr_idx),
    .wr_line_i  ('{x1: wr_x1, y1: wr_y1, x3: wr_x3, y3: wr_y3}),
    .tbl_clr_i  (tbl_clr),
    .rd_idx_i   (rd_idx),
    .rd_line_o  (rd_line),
    .rd_valid_o (rd_valid)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    chk_line_d  = chk_line_q;
    chk_valid_d = chk_valid_q;
    pix_lit_d   = pix_lit_q;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = CHECK;
            x_d         = '0;
            y_d         = '0;
            idx_d       = '0;
            acc_d       = 1'b0;
            chk_line_d  = rd_line;
            chk_valid_d = rd_valid;
          end
        end
        CHECK: begin
          acc_d = acc_q | (chk_on_segment & chk_valid_q);
          if (idx_q == idx_t'(MAX_LINES - 1)) begin
            state_d   = EMIT;
            pix_lit_d = acc_d;
          end else begin
            idx_d       = idx_t'(idx_q + 1'b1);
            chk_line_d  = rd_line;
            chk_valid_d = rd_valid;
          end
        end
        EMIT: begin
          if (pix_ready) begin
            if ((x_q == '1) && (y_q == '1)) begin
              state_d = DONE;
            end else begin
              x_d = coord_t'(x_q + 1'b1);
              if (x_q == '1) begin
                y_d = coord_t'(y_q + 1'b1);
              end
              acc_d       = 1'b0;
              idx_d       = '0;
              chk_line_d  = rd_line;
              chk_valid_d = rd_valid;
              state_d     = CHECK;
            end
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      idx_q       <= '0;
      acc_q       <= 1'b0;
      chk_line_q  <= '0;
      chk_valid_q <= 1'b0;
      pix_lit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      chk_line_q  <= chk_line_d;
      chk_valid_q <= chk_valid_d;
      pix_lit_q   <= pix_lit_d;
    end
  end

  assign chk_x1     = chk_line_q.x1;
  assign chk_y1     = chk_line_q.y1;
  assign chk_x3     = chk_line_q.x3;
  assign chk_y3     = chk_line_q.y3;
  assign chk_x2     = x_q;
  assign chk_y2     = y_q;

  assign pix_valid  = (state_q == EMIT);
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign pix_lit    = pix_lit_q;
  assign busy       = busy_w;
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_line_scan_sequencer.sv
// Directed bench for line_scan_sequencer with a reference on-line checker and
// a pixel scoreboard built from the bench's own copy of the line table.
`timescale 1ns/1ps
module tb_line_scan_sequencer;
  import spacewar_pkg::*;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               lit;
  } pix_t;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               en = 1'b1;
  logic               wr_en = 1'b0;
  logic [IDX_W-1:0]   wr_idx = '0;
  logic [COORD_W-1:0] wr_x1 = '0, wr_y1 = '0, wr_x3 = '0, wr_y3 = '0;
  logic               tbl_clr = 1'b0;
  logic               start = 1'b0;
  logic [COORD_W-1:0] chk_x1, chk_y1, chk_x2, chk_y2, chk_x3, chk_y3;
  logic               chk_on_segment;
  logic               pix_valid;
  logic               pix_ready = 1'b0;
  logic [COORD_W-1:0] pix_x, pix_y;
  logic               pix_lit, busy, frame_done;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lit_cnt;
  bit   lit_map [32][32];
  pix_t exp_q [$];

  int   m_x1 [MAX_LINES], m_y1 [MAX_LINES], m_x3 [MAX_LINES], m_y3 [MAX_LINES];
  bit   m_v  [MAX_LINES];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_scan_sequencer dut (
    .clk(clk), .reset(reset), .en(en),
    .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_x1(wr_x1), .wr_y1(wr_y1), .wr_x3(wr_x3), .wr_y3(wr_y3),
    .tbl_clr(tbl_clr), .start(start),
    .chk_x1(chk_x1), .chk_y1(chk_y1), .chk_x2(chk_x2),
    .chk_y2(chk_y2), .chk_x3(chk_x3), .chk_y3(chk_y3),
    .chk_on_segment(chk_on_segment),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_lit(pix_lit),
    .busy(busy), .frame_done(frame_done)
  );

  // Reference checker: point 2 lies on the closed segment from point 1 to point 3.
  function automatic bit on_seg(int x1, int y1, int x2, int y2, int x3, int y3);
    int cr;
    cr = (x2 - x1) * (y3 - y1) - (y2 - y1) * (x3 - x1);
    return (cr == 0) &&
           (x2 >= ((x1 < x3) ? x1 : x3)) && (x2 <= ((x1 < x3) ? x3 : x1)) &&
           (y2 >= ((y1 < y3) ? y1 : y3)) && (y2 <= ((y1 < y3) ? y3 : y1));
  endfunction

  assign chk_on_segment = on_seg(int'(chk_x1), int'(chk_y1), int'(chk_x2),
                                 int'(chk_y2), int'(chk_x3), int'(chk_y3));

  function automatic bit model_lit(int x, int y);
    bit r = 1'b0;
    for (int k = 0; k < MAX_LINES; k++)
      if (m_v[k] && on_seg(m_x1[k], m_y1[k], x, y, m_x3[k], m_y3[k])) r = 1'b1;
    return r;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic write_entry(input int idx, input int x1, input int y1,
                             input int x3, input int y3);
    wr_en = 1'b1;
    wr_idx = idx_t'(idx);
    wr_x1 = coord_t'(x1); wr_y1 = coord_t'(y1);
    wr_x3 = coord_t'(x3); wr_y3 = coord_t'(y3);
    m_x1[idx] = x1; m_y1[idx] = y1; m_x3[idx] = x3; m_y3[idx] = y3;
    m_v[idx] = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic clear_table();
    tbl_clr = 1'b1;
    for (int k = 0; k < MAX_LINES; k++) m_v[k] = 1'b0;
    @(posedge clk); #1;
    tbl_clr = 1'b0;
  endtask

  task automatic run_frame(input bit throttle, input bit poke, input bit stall_en,
                           input bit timing);
    int   start_edge, last_hs, hs_n, stall_left;
    bit   done_seen, prev_stalled, stall_started;
    pix_t cur, prev, e;
    hs_n = 0; done_seen = 0; prev_stalled = 0; stall_started = 0; stall_left = 0;
    prev = '0;
    lit_cnt = 0;
    for (int yy = 0; yy < 32; yy++)
      for (int xx = 0; xx < 32; xx++) begin
        lit_map[yy][xx] = 1'b0;
        exp_q.push_back('{x: coord_t'(xx), y: coord_t'(yy), lit: model_lit(xx, yy)});
      end
    pix_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1'b1;
    start_edge = cyc + 1;
    last_hs = start_edge;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 40000 && !done_seen; n++) begin
      @(negedge clk);
      cur = '{x: pix_x, y: pix_y, lit: pix_lit};
      if (stall_en && !stall_started && hs_n == 200 && pix_valid) begin
        en = 1'b0;
        stall_left = 20;
        stall_started = 1'b1;
      end
      if (prev_stalled) begin
        check("stall_valid", int'(pix_valid), 1);
        check("stall_data", int'(cur), int'(prev));
      end
      if (frame_done) begin
        done_seen = 1'b1;
        check("done_hs_count", hs_n, 1024);
        check("done_busy", int'(busy), 0);
        if (timing) check("done_after_last_hs", cyc + 1 - last_hs, 1);
      end
      if (n == 50 || n == 101) check("busy_mid_frame", int'(busy), 1);
      prev_stalled = pix_valid && !(pix_ready && en);
      prev = cur;
      if (pix_valid && pix_ready && en) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 0, 1);
        end else begin
          e = exp_q.pop_front();
          check("pixel", int'(cur), int'(e));
        end
        if (timing) check("hs_spacing", cyc + 1 - last_hs, MAX_LINES + 1);
        last_hs = cyc + 1;
        hs_n++;
        if (pix_lit) begin
          lit_cnt++;
          lit_map[pix_y][pix_x] = 1'b1;
        end
      end
      @(posedge clk); #1;
      wr_en = 1'b0; tbl_clr = 1'b0; start = 1'b0;
      if (throttle) pix_ready = 1'($urandom_range(0, 1));
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) en = 1'b1;
      end
      if (poke) begin
        // These are all expected to be ignored, so the model is left untouched.
        if (n == 100) begin
          wr_en = 1'b1; wr_idx = 1;
          wr_x1 = 0; wr_y1 = 20; wr_x3 = 20; wr_y3 = 0;
        end
        if (n == 101) tbl_clr = 1'b1;
        if (n == 102) start = 1'b1;
      end
    end
    if (!done_seen) check("frame_timeout", 0, 1);
    check("sb_empty", exp_q.size(), 0);
    exp_q.delete();
    en = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    bit found;
    for (int k = 0; k < MAX_LINES; k++) m_v[k] = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pix_valid", int'(pix_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_pix_xy_lit", int'({pix_x, pix_y, pix_lit}), 0);
    check("rst_chk", int'({chk_x1, chk_y1, chk_x2, chk_y2, chk_x3, chk_y3}), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Empty table
    run_frame(0, 0, 0, 1);
    check("empty_lit_cnt", lit_cnt, 0);

    // Main diagonal
    write_entry(0, 0, 0, 31, 31);
    run_frame(0, 0, 0, 1);
    check("diag_lit_cnt", lit_cnt, 32);
    check("diag_5_5", int'(lit_map[5][5]), 1);
    check("diag_5_6", int'(lit_map[6][5]), 0);

    // Row 3 and column 10, then clear and keep only row 3
    write_entry(2, 0, 3, 31, 3);
    write_entry(7, 10, 0, 10, 31);
    clear_table();
    write_entry(2, 0, 3, 31, 3);
    run_frame(0, 0, 0, 1);
    check("row3_lit_cnt", lit_cnt, 32);
    check("row3_10_3", int'(lit_map[3][10]), 1);
    check("row3_10_5", int'(lit_map[5][10]), 0);
    check("row3_0_3", int'(lit_map[3][0]), 1);

    // Same table, random backpressure
    run_frame(1, 0, 0, 0);
    check("throttle_lit_cnt", lit_cnt, 32);

    // Writes, clear and restart while busy must all be ignored
    run_frame(0, 1, 0, 1);
    check("lockout_lit_cnt", lit_cnt, 32);

    // The same write after the frame takes effect; en stall mid-EMIT
    write_entry(1, 0, 20, 20, 0);
    run_frame(0, 0, 1, 0);
    check("antidiag_lit_cnt", lit_cnt, 52);
    check("antidiag_17_3", int'(lit_map[3][17]), 1);
    check("antidiag_5_15", int'(lit_map[15][5]), 1);

    // Reset while presenting pixel (12,4)
    pix_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      @(negedge clk);
      if (pix_valid && pix_x == 5'd12 && pix_y == 5'd4) begin
        found = 1'b1;
        reset = 1'b0;
        #1;
      end
    end
    check("reset_point_reached", int'(found), 1);
    check("midrst_pix_valid", int'(pix_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_pix_xy_lit", int'({pix_x, pix_y, pix_lit}), 0);
    check("midrst_chk", int'({chk_x1, chk_y1, chk_x2, chk_y2, chk_x3, chk_y3}), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      check("postrst_no_done", int'(frame_done), 0);
      check("postrst_idle", int'(busy), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
